// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 console I/O bridge.
// Holds the bridge state encoding and the ASCII line terminators.
// No logic, no latency, no flow control.
package ej32_pkg;

    typedef enum logic [1:0] {
        RX  = 2'd0,
        RUN = 2'd1,
        RD  = 2'd2,
        TX  = 2'd3
    } cio_st_t;

    localparam logic [7:0] ASC_CR = 8'h0d;
    localparam logic [7:0] ASC_LF = 8'h0a;

    // Either terminator ends a line; neither is ever stored in the TIB.
    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASC_CR) || (b == ASC_LF);
    endfunction

endpackage

// File: rtl/ej32_cio.sv
// Console bridge: host line -> TIB, release core, drain OBUF -> host.
// Latency: TIB write in the rx handshake cycle; core_done to first tx_vld 2 cycles; 2 cycles/byte out.
// Backpressure: rx_rdy only in RX; tx_vld holds with stable tx_dat until tx_rdy.
module ej32_cio
    import ej32_pkg::*;
#(
    parameter int TIB     = 'h1000,
    parameter int OBUF    = 'h1400,
    parameter int ASZ     = 17,
    parameter int TIB_SZ  = 256,
    parameter int OBUF_SZ = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_vld,
    output logic                       rx_rdy,
    input  logic [7:0]                 rx_dat,
    output logic                       tx_vld,
    input  logic                       tx_rdy,
    output logic [7:0]                 tx_dat,
    output logic                       mem_own,
    output logic                       mem_we,
    output logic [ASZ-1:0]             mem_a,
    output logic [7:0]                 mem_vi,
    input  logic [7:0]                 mem_vo,
    output logic                       core_go,
    input  logic                       core_done,
    input  logic [$clog2(OBUF_SZ):0]   ob_len,
    output logic [$clog2(TIB_SZ):0]    tib_len,
    output logic                       ovf
);

    localparam int IW = $clog2(TIB_SZ) + 1;
    localparam int OW = $clog2(OBUF_SZ) + 1;

    localparam logic [ASZ-1:0] TIB_A    = ASZ'(TIB);
    localparam logic [ASZ-1:0] OBUF_A   = ASZ'(OBUF);
    localparam logic [IW-1:0]  TIB_FULL = IW'(TIB_SZ);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [OW-1:0]  OBUF_MAX = OW'(OBUF_SZ);
    localparam logic [OW-1:0]  K_ONE    = OW'(1);

    cio_st_t        st;
    cio_st_t        st_nx;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_inc;
    logic [OW-1:0]  k;
    logic [OW-1:0]  k_inc;
    logic [OW-1:0]  len;
    logic [OW-1:0]  len_cap;
    logic           rx_hs;
    logic           rx_wr;
    logic           line_end;
    logic           line_full;
    logic           last_byte;

    // Handshake decode and line/run bookkeeping conditions.
    always_comb begin
        idx_inc   = idx + IDX_ONE;
        k_inc     = k + K_ONE;
        rx_hs     = (st == RX) && rx_vld;
        // Gated by rst_n so an rx byte arriving during reset never strobes the SRAM.
        rx_wr     = rx_hs && !is_eol(rx_dat) && rst_n;
        line_end  = rx_hs && is_eol(rx_dat) && (idx != '0);
        line_full = rx_wr && (idx_inc == TIB_FULL);
        len_cap   = (ob_len > OBUF_MAX) ? OBUF_MAX : ob_len;
        last_byte = (k_inc == len);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= RX;
        end else begin
            st <= st_nx;
        end
    end

    // Next state and all port-facing outputs, decoded from the current state only
    // (plus the rx byte for the same-cycle TIB write), so mem_own flips on state edges.
    always_comb begin
        st_nx   = st;
        rx_rdy  = 1'b0;
        tx_vld  = 1'b0;
        mem_own = 1'b1;
        mem_we  = 1'b0;
        mem_a   = TIB_A;
        mem_vi  = 8'h00;
        core_go = 1'b0;
        case (st)
            RX: begin
                rx_rdy = 1'b1;
                mem_a  = TIB_A + ASZ'(idx);
                if (rx_wr) begin
                    mem_we = 1'b1;
                    mem_vi = rx_dat;
                end
                if (line_end || line_full) begin
                    st_nx = RUN;
                end
            end
            RUN: begin
                mem_own = 1'b0;
                core_go = 1'b1;
                if (core_done) begin
                    st_nx = (len_cap == '0) ? RX : RD;
                end
            end
            RD: begin
                mem_a = OBUF_A + ASZ'(k);
                st_nx = TX;
            end
            TX: begin
                tx_vld = 1'b1;
                mem_a  = OBUF_A + ASZ'(k);
                if (tx_rdy) begin
                    st_nx = last_byte ? RX : RD;
                end
            end
            default: st_nx = RX;
        endcase
    end

    // Line index, output cursor, line status and the held tx byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            k       <= '0;
            len     <= '0;
            tib_len <= '0;
            ovf     <= 1'b0;
            tx_dat  <= 8'h00;
        end else begin
            case (st)
                RX: begin
                    if (rx_wr) begin
                        idx <= idx_inc;
                    end
                    if (line_end) begin
                        tib_len <= idx;
                        ovf     <= 1'b0;
                    end else if (line_full) begin
                        // Overflow splits the line: the rest of the host bytes start the next one.
                        tib_len <= TIB_FULL;
                        ovf     <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        len <= len_cap;
                        k   <= '0;
                        // The line has been consumed; the next RX always starts at TIB.
                        idx <= '0;
                    end
                end
                RD: begin
                    tx_dat <= mem_vo;
                end
                TX: begin
                    if (tx_rdy) begin
                        k <= k_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ej32_cio.sv
module tb_ej32_cio;

    localparam int ASZ     = 17;
    localparam int TIB     = 'h1000;
    localparam int OBUF    = 'h1400;
    localparam int TIB_SZ  = 256;
    localparam int OBUF_SZ = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_vld;
    logic            rx_rdy;
    logic [7:0]      rx_dat;
    logic            tx_vld;
    logic            tx_rdy;
    logic [7:0]      tx_dat;
    logic            mem_own;
    logic            mem_we;
    logic [ASZ-1:0]  mem_a;
    logic [7:0]      mem_vi;
    logic [7:0]      mem_vo;
    logic            core_go;
    logic            core_done;
    logic [10:0]     ob_len;
    logic [8:0]      tib_len;
    logic            ovf;

    int checks = 0;
    int errors = 0;
    int pos    = 0;
    logic [7:0] expq[$];
    logic [7:0] mem [0:(1<<ASZ)-1];

    ej32_cio #(
        .TIB(TIB), .OBUF(OBUF), .ASZ(ASZ), .TIB_SZ(TIB_SZ), .OBUF_SZ(OBUF_SZ)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_dat(rx_dat),
        .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_dat(tx_dat),
        .mem_own(mem_own), .mem_we(mem_we), .mem_a(mem_a),
        .mem_vi(mem_vi), .mem_vo(mem_vo),
        .core_go(core_go), .core_done(core_done), .ob_len(ob_len),
        .tib_len(tib_len), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // SRAM model: ticks on the falling edge, read data valid one cycle after the address.
    always @(negedge clk) begin
        if (mem_own && mem_we) mem[mem_a] = mem_vi;
        mem_vo <= mem[mem_a];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rbyte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h0d || b == 8'h0a);
        return b;
    endfunction

    task automatic chk_reset();
        chk("rst_rx_rdy",  32'(rx_rdy),  1);
        chk("rst_tx_vld",  32'(tx_vld),  0);
        chk("rst_tx_dat",  32'(tx_dat),  0);
        chk("rst_mem_own", 32'(mem_own), 1);
        chk("rst_mem_we",  32'(mem_we),  0);
        chk("rst_mem_a",   32'(mem_a),   TIB);
        chk("rst_mem_vi",  32'(mem_vi),  0);
        chk("rst_core_go", 32'(core_go), 0);
        chk("rst_tib_len", 32'(tib_len), 0);
        chk("rst_ovf",     32'(ovf),     0);
    endtask

    // One host byte in RX; the model tracks the line position from the line rules.
    task automatic send_byte(input logic [7:0] b);
        logic term;
        int   p;
        term   = (b == 8'h0d) || (b == 8'h0a);
        p      = pos;
        rx_vld = 1'b1;
        rx_dat = b;
        #1;
        chk("rx_rdy", 32'(rx_rdy), 1);
        if (!term) begin
            chk("wr_we",   32'(mem_we), 1);
            chk("wr_addr", 32'(mem_a),  TIB + pos);
            chk("wr_data", 32'(mem_vi), 32'(b));
            pos++;
        end else begin
            chk("term_no_we", 32'(mem_we), 0);
        end
        step();
        rx_vld = 1'b0;
        rx_dat = 8'h00;
        if (term && p > 0) begin
            chk("line_go",   32'(core_go), 1);
            chk("line_len",  32'(tib_len), p);
            chk("line_ovf",  32'(ovf),     0);
            chk("line_own",  32'(mem_own), 0);
            pos = 0;
        end else if (term) begin
            chk("bare_go",  32'(core_go), 0);
            chk("bare_rdy", 32'(rx_rdy),  1);
        end else if (pos == TIB_SZ) begin
            chk("full_go",  32'(core_go), 1);
            chk("full_len", 32'(tib_len), TIB_SZ);
            chk("full_ovf", 32'(ovf),     1);
            pos = 0;
        end else begin
            chk("mid_go", 32'(core_go), 0);
        end
    endtask

    // mode 0: tx_rdy held high; 1: random tx_rdy; 2: five-cycle stall after first byte.
    task automatic drain(input int m, input int mode);
        int got, cyc, last, stall, budget;
        logic held;
        logic [7:0] hd, e;
        got = 0; cyc = 0; last = 0; stall = 0; held = 1'b0; hd = 8'h00;
        budget = 8 * m + 50;
        while (got < m && cyc < budget) begin
            case (mode)
                0: tx_rdy = 1'b1;
                1: tx_rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (got == 1 && stall < 5) begin
                        tx_rdy = 1'b0;
                        stall++;
                    end else tx_rdy = 1'b1;
                end
            endcase
            #1;
            if (held) begin
                chk("hold_vld", 32'(tx_vld), 1);
                chk("hold_dat", 32'(tx_dat), 32'(hd));
            end
            if (tx_vld && tx_rdy) begin
                e = expq.pop_front();
                chk("tx_dat", 32'(tx_dat), 32'(e));
                if (mode == 0 && got == 0) chk("first_tx_cyc", cyc, 1);
                if (mode == 0 && got > 0)  chk("tx_gap", cyc - last, 2);
                last = cyc;
                got++;
                held = 1'b0;
            end else begin
                held = tx_vld;
                hd   = tx_dat;
            end
            step();
            cyc++;
        end
        tx_rdy = 1'b0;
        if (got < m) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d bytes expected %0d", got, m);
        end
        chk("end_rx_rdy",  32'(rx_rdy),  1);
        chk("end_tx_vld",  32'(tx_vld),  0);
        chk("end_mem_own", 32'(mem_own), 1);
    endtask

    // Acts as the core: fills OBUF, reports n bytes, then the bridge drains them.
    task automatic core_run(input int n, input int mode);
        int m;
        logic [7:0] b;
        m = (n > OBUF_SZ) ? OBUF_SZ : n;
        expq.delete();
        for (int i = 0; i < m; i++) begin
            b = 8'($urandom);
            mem[OBUF + i] = b;
            expq.push_back(b);
        end
        chk("run_go", 32'(core_go), 1);
        repeat ($urandom_range(0, 3)) begin
            step();
            chk("run_wait_go",  32'(core_go), 1);
            chk("run_wait_own", 32'(mem_own), 0);
        end
        core_done = 1'b1;
        ob_len    = 11'(n);
        step();
        core_done = 1'b0;
        ob_len    = 11'($urandom);
        if (m == 0) begin
            chk("empty_rx_rdy", 32'(rx_rdy),  1);
            chk("empty_go",     32'(core_go), 0);
        end else begin
            chk("rd_tx_vld", 32'(tx_vld), 0);
            chk("rd_addr",   32'(mem_a),  OBUF);
            drain(m, mode);
        end
        // A stray core_done in RX must not start anything.
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("stray_done_rdy", 32'(rx_rdy),  1);
        chk("stray_done_vld", 32'(tx_vld),  0);
        chk("stray_done_go",  32'(core_go), 0);
    endtask

    initial begin
        logic [7:0] line1 [6];
        int n;
        line1[0] = 8'h31; line1[1] = 8'h20; line1[2] = 8'h32;
        line1[3] = 8'h20; line1[4] = 8'h2b; line1[5] = 8'h0d;

        rst_n = 1'b0; rx_vld = 1'b0; rx_dat = 8'h00; tx_rdy = 1'b0;
        core_done = 1'b0; ob_len = '0;
        #3;
        chk_reset();
        step();
        rst_n = 1'b1;
        step();

        // Bare terminators from reset: nothing stored, no run.
        send_byte(8'h0a);
        send_byte(8'h0d);
        send_byte(8'h0a);
        chk("bare_tib_len", 32'(tib_len), 0);

        // "1 2 +\r" back to back, then "3 o" out.
        for (int i = 0; i < 6; i++) send_byte(line1[i]);
        for (int i = 0; i < 5; i++) chk("tib_mem", 32'(mem[TIB + i]), 32'(line1[i]));
        expq.delete();
        mem[OBUF] = 8'h33; mem[OBUF + 1] = 8'h20; mem[OBUF + 2] = 8'h6f;
        expq.push_back(8'h33); expq.push_back(8'h20); expq.push_back(8'h6f);
        core_done = 1'b1; ob_len = 11'd3;
        step();
        core_done = 1'b0;
        chk("ex_rd_vld", 32'(tx_vld), 0);
        drain(3, 0);

        // "\r\n" after a line: LF arrives in RX and is dropped.
        send_byte(8'h41);
        send_byte(8'h0d);
        core_run(2, 0);
        send_byte(8'h0a);

        // 300 bytes: overflow at 256, remainder starts the next line at TIB.
        for (int i = 0; i < 256; i++) send_byte(rbyte());
        core_run(0, 0);
        for (int i = 0; i < 44; i++) send_byte(rbyte());
        chk("split_pos", pos, 44);
        send_byte(8'h0d);
        core_run(4, 2);

        // Randomized lines, terminators and throttled drains.
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'h0a);
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) send_byte(rbyte());
            send_byte($urandom_range(0, 1) == 1 ? 8'h0d : 8'h0a);
            core_run($urandom_range(0, 6), 1);
        end

        // ob_len beyond OBUF_SZ is clamped.
        send_byte(8'h58);
        send_byte(8'h0d);
        core_run(1100, 0);

        // Reset while a byte is waiting on tx.
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h0d);
        expq.delete();
        mem[OBUF] = 8'h11; mem[OBUF + 1] = 8'h22; mem[OBUF + 2] = 8'h33;
        core_done = 1'b1; ob_len = 11'd3;
        step();
        core_done = 1'b0;
        step();
        chk("pre_rst_tx_vld", 32'(tx_vld), 1);
        chk("pre_rst_tx_dat", 32'(tx_dat), 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        step();
        rst_n = 1'b1;
        pos = 0;
        step();

        // Reset during RUN, and a partial line discarded by reset.
        send_byte(8'h78); send_byte(8'h79); send_byte(8'h0d);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        step();
        rst_n = 1'b1;
        pos = 0;
        step();
        send_byte(8'h70); send_byte(8'h71);
        rst_n = 1'b0;
        #1;
        chk_reset();
        step();
        rst_n = 1'b1;
        pos = 0;
        step();
        send_byte(8'h7a);
        send_byte(8'h0d);
        core_run(1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
